// File: rtl/rst_sub_encoder.sv
// Substitution encoder: looks up each plaintext character in the inner 6x6 block
// and emits the row header then the column header. Optional macro: RST_UPPERCASE_FOLD_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a plaintext character, ready while table valid
// LOOKUP   | registered character compared against all 36 inner cells
// EMIT_ROW | row header presented, held until downstream accepts
// EMIT_COL | column header presented, pair counted on acceptance
module rst_sub_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       sub_char [7][7],
   input  logic             table_valid,
   input  logic             ptxt_valid,
   input  logic [7:0]       ptxt_char,
   output logic             ptxt_ready,
   output logic             ctxt_valid,
   output logic [7:0]       ctxt_char,
   input  logic             ctxt_ready,
   output logic             err_invalid_ptxt_char,
   output logic             busy,
   output logic [CNT_W-1:0] enc_count
);

   typedef enum logic [1:0] {IDLE, LOOKUP, EMIT_ROW, EMIT_COL} state_t;

   state_t           state_q, state_d;
   logic [7:0]       char_q, char_d;
   logic [7:0]       ctxt_char_q, ctxt_char_d;
   logic [2:0]       row_q, row_d;
   logic [2:0]       col_q, col_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [7:0]       lookup_char;
   logic             hit;
   logic [2:0]       hit_row, hit_col;

`ifdef RST_UPPERCASE_FOLD_EN
   always_comb begin
      lookup_char = char_q;
      if (char_q >= 8'h41 && char_q <= 8'h5A)
         lookup_char = char_q + 8'h20;
   end
`else
   assign lookup_char = char_q;
`endif

   // Scan from the highest index down so the lowest row, then lowest column, wins.
   always_comb begin
      hit     = 1'b0;
      hit_row = 3'd1;
      hit_col = 3'd1;
      for (int r = 6; r >= 1; r--) begin
         for (int c = 6; c >= 1; c--) begin
            if (sub_char[r][c] == lookup_char) begin
               hit     = 1'b1;
               hit_row = 3'(r);
               hit_col = 3'(c);
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      char_d      = char_q;
      row_d       = row_q;
      col_d       = col_q;
      ctxt_char_d = ctxt_char_q;
      err_d       = 1'b0;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (ptxt_valid && table_valid) begin
               char_d  = ptxt_char;
               state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (!table_valid) begin
               state_d = IDLE;
            end else if (hit) begin
               row_d       = hit_row;
               col_d       = hit_col;
               ctxt_char_d = sub_char[hit_row][0];
               state_d     = EMIT_ROW;
            end else begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         EMIT_ROW: begin
            if (!table_valid) begin
               state_d = IDLE;
            end else if (ctxt_ready) begin
               ctxt_char_d = sub_char[0][col_q];
               state_d     = EMIT_COL;
            end
         end
         EMIT_COL: begin
            if (!table_valid) begin
               state_d = IDLE;
            end else if (ctxt_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         char_q      <= 8'h00;
         ctxt_char_q <= 8'h00;
         row_q       <= 3'd0;
         col_q       <= 3'd0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         char_q      <= char_d;
         ctxt_char_q <= ctxt_char_d;
         row_q       <= row_d;
         col_q       <= col_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   end

   // rst_n gate keeps ready low while reset is held.
   assign ptxt_ready            = rst_n && table_valid && (state_q == IDLE);
   assign ctxt_valid            = (state_q == EMIT_ROW) || (state_q == EMIT_COL);
   assign ctxt_char             = ctxt_char_q;
   assign err_invalid_ptxt_char = err_q;
   assign busy                  = (state_q != IDLE);
   assign enc_count             = cnt_q;

endmodule
